// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-requester round-robin arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package arb_pkg;

   localparam int N_REQ = 4;
   localparam int IDX_W = 2;

   typedef enum logic {IDLE, GRANT} arb_state_t;

   // One-hot winner: first set bit scanning ptr, ptr+1, ... with 2-bit wrap.
   function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                input logic [IDX_W-1:0] ptr);
      logic [N_REQ-1:0] win;
      logic             found;
      logic [IDX_W-1:0] pos;
      win   = '0;
      found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         pos = ptr + IDX_W'(k);
         if (!found && req[pos]) begin
            win[pos] = 1'b1;
            found    = 1'b1;
         end
      end
      return win;
   endfunction

   // Binary index of a one-hot vector (only ever fed a single set bit).
   function automatic logic [IDX_W-1:0] oh_to_idx(input logic [N_REQ-1:0] oh);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (oh[k]) idx = IDX_W'(k);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter_4req_enc.sv
// One-hot to binary encoder for the arbiter grant vector.
// Latency: combinational, zero cycles.
// Backpressure: none; invalid (zero or multi-hot) input encodes to 2'b00.
module onehot_enc4
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] onehot,
   output logic [IDX_W-1:0] idx
);

   // Only legal one-hot codes map to a non-zero index.
   always_comb begin
      idx = '0;
      case (onehot)
         4'b0001: idx = 2'd0;
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
   end

endmodule

// File: rtl/rr_arbiter_4req.sv
// 4-requester round-robin arbiter with grant hold; optional tenure watchdog (ARB_WATCHDOG_EN).
// Latency: grant registered, visible the cycle after req is sampled; owner switch has no bubble.
// Backpressure: owner holds grant while its req stays high; others wait (or preempt via watchdog).
module rr_arbiter_4req
   import arb_pkg::*;
#(
   parameter  int MAX_HOLD = 16,
   localparam int HOLD_W   = $clog2(MAX_HOLD)
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             preempt
);

   arb_state_t       state, state_n;
   logic [N_REQ-1:0] gnt_n;
   logic [IDX_W-1:0] ptr, ptr_n;
   logic [N_REQ-1:0] masked;
   logic [N_REQ-1:0] pick_all;
   logic [N_REQ-1:0] pick_msk;
   logic             owner_req;
   logic             revoke;

   // The owner is excluded from re-arbitration so a release always hands over.
   assign masked    = req & ~gnt;
   assign owner_req = |(req & gnt);
   assign pick_all  = rr_pick(req, ptr);
   assign pick_msk  = rr_pick(masked, ptr);

   // Next-state, next-grant and pointer decision.
   always_comb begin
      state_n = state;
      gnt_n   = gnt;
      ptr_n   = ptr;
      case (state)
         IDLE: begin
            if (|req) begin
               state_n = GRANT;
               gnt_n   = pick_all;
               ptr_n   = oh_to_idx(pick_all) + 2'd1;
            end
         end
         GRANT: begin
            if (owner_req && !revoke) begin
               gnt_n = gnt;
            end else if (|masked) begin
               gnt_n = pick_msk;
               ptr_n = oh_to_idx(pick_msk) + 2'd1;
            end else begin
               state_n = IDLE;
               gnt_n   = '0;
            end
         end
         default: begin
            state_n = IDLE;
            gnt_n   = '0;
         end
      endcase
   end

   // State, grant and priority pointer registers; reset drops the grant at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         gnt   <= '0;
         ptr   <= '0;
      end else begin
         state <= state_n;
         gnt   <= gnt_n;
         ptr   <= ptr_n;
      end
   end

`ifdef ARB_WATCHDOG_EN
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   logic [HOLD_W-1:0] hold_cnt;
   logic              preempt_q;

   // Revoke only when someone else is waiting; otherwise the owner keeps it.
   assign revoke = (hold_cnt == HOLD_LAST) && (|masked);

   // Tenure counter: clears on each new grant, saturates at the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt <= '0;
      end else if ((gnt_n != gnt) && (|gnt_n)) begin
         hold_cnt <= '0;
      end else if ((state == GRANT) && (hold_cnt != HOLD_LAST)) begin
         hold_cnt <= hold_cnt + 1'b1;
      end
   end

   // One-cycle pulse aligned with the grant that replaced a revoked owner.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         preempt_q <= 1'b0;
      end else begin
         preempt_q <= (state == GRANT) && owner_req && revoke;
      end
   end

   assign preempt = preempt_q;
`else
   assign revoke  = 1'b0;
   assign preempt = 1'b0;
`endif

   onehot_enc4 u_enc (
      .onehot (gnt),
      .idx    (gnt_idx)
   );

   assign gnt_valid = |gnt;

   gnt_onehot_a: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));

endmodule

// File: tb/tb_rr_arbiter_4req.sv
module tb_rr_arbiter_4req;

`ifdef ARB_WATCHDOG_EN
   localparam bit WD      = 1'b1;
   localparam int TB_HOLD = 4;
`else
   localparam bit WD      = 1'b0;
   localparam int TB_HOLD = 16;
`endif

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_valid;
   logic       preempt;

   int checks = 0;
   int errors = 0;

   // reference model state: owner agent (-1 idle), priority start, cycles owned
   int m_owner;
   int m_ptr;
   int m_ten;
   bit m_pre;

   rr_arbiter_4req #(.MAX_HOLD(TB_HOLD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .preempt   (preempt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] idx;
   } vec_t;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++) begin
         if (r[(p + k) % 4]) return (p + k) % 4;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_ten   = 0;
      m_pre   = 1'b0;
   endtask

   task automatic model_step(input logic [3:0] r);
      logic [3:0] others;
      m_pre = 1'b0;
      if (m_owner < 0) begin
         if (r != 4'b0) begin
            m_owner = pick(r, m_ptr);
            m_ptr   = (m_owner + 1) % 4;
            m_ten   = 1;
         end
      end else begin
         others = r;
         others[m_owner] = 1'b0;
         if (r[m_owner] && !(WD && m_ten >= TB_HOLD && others != 4'b0)) begin
            m_ten++;
         end else if (others != 4'b0) begin
            m_pre   = r[m_owner];
            m_owner = pick(others, m_ptr);
            m_ptr   = (m_owner + 1) % 4;
            m_ten   = 1;
         end else begin
            m_owner = -1;
         end
      end
   endtask

   task automatic cmp_model(input string tag);
      logic [3:0] eg;
      logic [1:0] ei;
      eg = (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
      ei = (m_owner < 0) ? 2'd0 : 2'(m_owner);
      chk({tag, ".gnt"},   8'(gnt),       8'(eg));
      chk({tag, ".idx"},   8'(gnt_idx),   8'(ei));
      chk({tag, ".valid"}, 8'(gnt_valid), 8'(m_owner >= 0));
      chk({tag, ".pre"},   8'(preempt),   8'(m_pre));
   endtask

   // drive at negedge, sample 1 time unit after the posedge, end at negedge
   task automatic step(input logic [3:0] r, input string tag);
      req = r;
      @(posedge clk);
      model_step(r);
      #1;
      cmp_model(tag);
      @(negedge clk);
   endtask

   task automatic do_reset(input logic [3:0] r);
      rst_n = 1'b0;
      req   = r;
      repeat (2) @(posedge clk);
      model_reset();
      #1;
      chk("rst.gnt",   8'(gnt),       8'h0);
      chk("rst.idx",   8'(gnt_idx),   8'h0);
      chk("rst.valid", 8'(gnt_valid), 8'h0);
      chk("rst.pre",   8'(preempt),   8'h0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   vec_t tbl[6];
   logic [3:0] rq;

   initial begin
      tbl[0] = '{4'b1111, 4'b0001, 2'd0};
      tbl[1] = '{4'b1110, 4'b0010, 2'd1};
      tbl[2] = '{4'b1101, 4'b0100, 2'd2};
      tbl[3] = '{4'b1011, 4'b1000, 2'd3};
      tbl[4] = '{4'b0111, 4'b0001, 2'd0};
      tbl[5] = '{4'b1111, 4'b0001, 2'd0};

      rst_n = 1'b1;
      req   = 4'b0;
      model_reset();
      @(negedge clk);

      // reset with all requesting, then rotation 0,1,2,3,0 without bubbles
      do_reset(4'b1111);
      for (int i = 0; i < 6; i++) begin
         step(tbl[i].req, "rot");
         chk("rot.tbl_gnt", 8'(gnt),     8'(tbl[i].gnt));
         chk("rot.tbl_idx", 8'(gnt_idx), 8'(tbl[i].idx));
      end

      // hold: agent 2 keeps the grant for 10 cycles while agent 0 waits
      do_reset(4'b0000);
      for (int i = 1; i <= 10; i++) begin
         step((i >= 3) ? 4'b0101 : 4'b0100, "hold");
`ifndef ARB_WATCHDOG_EN
         chk("hold.gnt", 8'(gnt), 8'h04);
`endif
      end
      step(4'b0001, "hold_x");
      chk("hold.handover", 8'(gnt), 8'h01);

      // idle return and pointer wrap after agent 3
      do_reset(4'b0000);
      for (int i = 0; i < 3; i++) begin
         step(4'b1000, "idle");
         chk("idle.gnt3", 8'(gnt), 8'h08);
      end
      step(4'b0000, "idle0");
      chk("idle.none", 8'(gnt), 8'h00);
      step(4'b1001, "wrap");
      chk("wrap.gnt", 8'(gnt), 8'h01);

      // asynchronous reset in the middle of a tenure
      do_reset(4'b0000);
      step(4'b0001, "ar0");
      step(4'b0010, "ar1");
      chk("ar.gnt1", 8'(gnt), 8'h02);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar.async_gnt", 8'(gnt), 8'h00);
      chk("ar.async_valid", 8'(gnt_valid), 8'h00);
      do_reset(4'b0000);
      step(4'b1111, "ar_ptr");
      chk("ar.ptr0", 8'(gnt), 8'h01);

`ifdef ARB_WATCHDOG_EN
      // watchdog: agent 0 owns 4 cycles then is revoked in favour of agent 1
      do_reset(4'b0000);
      for (int i = 0; i < 4; i++) begin
         step(4'b0011, "wd");
         chk("wd.own0", 8'(gnt), 8'h01);
         chk("wd.nopre", 8'(preempt), 8'h0);
      end
      step(4'b0011, "wd_rev");
      chk("wd.gnt1", 8'(gnt), 8'h02);
      chk("wd.pulse", 8'(preempt), 8'h1);
      step(4'b0011, "wd_after");
      chk("wd.pulse_end", 8'(preempt), 8'h0);
      do_reset(4'b0000);
      for (int i = 0; i < 8; i++) begin
         step(4'b0001, "wd_solo");
         chk("wd.solo_gnt", 8'(gnt), 8'h01);
         chk("wd.solo_pre", 8'(preempt), 8'h0);
      end
`endif

      // randomized traffic against the reference model
      do_reset(4'b0000);
      rq = 4'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(3) == 0) rq = 4'($urandom_range(15));
         step(rq, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
